flow_counter_lookup: RTL and testbench

Upstream stage of the probabilistic flow-counter update pipeline. Holds the per-flow counter table indexed by flow ID and reads the current counter for each arriving packet. Small counters produce an exact length-add value. Large counters produce a probability threshold `pd` for the downstream update stage, which writes the resulting counter back into this table. An in-flight scoreboard prevents read-after-write hazards on the same flow ID.

---
 rtl/flow_counter_lookup_pkg.sv | 62 ++++++
 rtl/flow_counter_lookup_if.sv | 60 ++++++
 rtl/flow_counter_ram.sv | 46 ++++
 rtl/flow_counter_lookup.sv | 228 ++++++++++++++++++++++
 tb/tb_flow_counter_lookup.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/flow_counter_lookup_pkg.sv
// ---------------------------------------------------------------------------
// flow_counter_lookup_pkg
// Shared definitions for the flow-counter lookup stage and its neighbours:
//   - default widths for length, flow ID, counter and probability threshold
//   - controller state enum (INIT clears the table, RUN serves packets)
//   - sat_add : saturating add clipped to a given result width
//   - pd_calc : probability threshold for the large-counter path
// The helpers work on 64-bit values so that any instance width up to 64 can
// share them; callers narrow the result with a size cast.
// ---------------------------------------------------------------------------
package flow_counter_lookup_pkg;

  localparam int LP_LENGTH_WIDTH  = 16;
  localparam int LP_ID_WIDTH      = 12;
  localparam int LP_COUNTER_WIDTH = 20;
  localparam int LP_PD_WIDTH      = 32;
  localparam int LP_SMALL_THRESH  = 16;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // All-ones value of the given width (w >= 64 gives all 64 bits set).
  function automatic logic [63:0] ones64(input int unsigned w);
    if (w >= 64) begin
      return '1;
    end
    return (64'd1 << w) - 64'd1;
  endfunction

  // a + b, clipped to the largest value representable in w bits.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int unsigned w);
    logic [63:0] sum;
    sum = a + b;
    if (sum > ones64(w)) begin
      return ones64(w);
    end
    return sum;
  endfunction

  // Threshold for a counter c at or above thresh: all-ones >> (c-thresh+1).
  // A shift of the full pd width or more leaves nothing, and a counter at
  // its maximum is frozen by returning 0 so it can never be incremented.
  function automatic logic [63:0] pd_calc(input logic [63:0] c,
                                          input logic [63:0] thresh,
                                          input int unsigned cw,
                                          input int unsigned pw);
    logic [63:0] shift;
    if (c == ones64(cw)) begin
      return 64'd0;
    end
    shift = c - thresh + 64'd1;
    if (shift >= 64'(pw)) begin
      return 64'd0;
    end
    return ones64(pw) >> shift;
  endfunction

endpackage

// File: rtl/flow_counter_lookup_if.sv
// ---------------------------------------------------------------------------
// flow_counter_lookup_if
// Bundles the packet descriptor handshake, the lookup results, the
// write-back channel from the update stage and the status flags.
//   master : upstream source + downstream update stage (drives in_*)
//   slave  : flow_counter_lookup (drives in_ready and out_*)
//
// Handshake: a descriptor transfers on a clock edge where in_pkt_valid and
// in_ready are both 1; in_ready may depend combinationally on in_pkt_id, so
// a source holds valid/id/len stable until the transfer occurs.
// Results (out_gen_counter_valid / out_pd_valid) are single-cycle pulses with
// no back-pressure; the update stage must answer one cycle later through
// in_update_valid / in_id_data_next / in_counter_data_new.
// ---------------------------------------------------------------------------
interface flow_counter_lookup_if
  import flow_counter_lookup_pkg::*;
#(
  parameter int C_LENGTH_WIDTH  = LP_LENGTH_WIDTH,
  parameter int C_ID_WIDTH      = LP_ID_WIDTH,
  parameter int C_COUNTER_WIDTH = LP_COUNTER_WIDTH,
  parameter int C_PD_WIDTH      = LP_PD_WIDTH
) ();

  logic                       in_pkt_valid;
  logic [C_ID_WIDTH-1:0]      in_pkt_id;
  logic [C_LENGTH_WIDTH-1:0]  in_pkt_len;
  logic                       in_ready;

  logic                       out_gen_counter_valid;
  logic [C_COUNTER_WIDTH-1:0] out_gen_counter_value;
  logic                       out_pd_valid;
  logic [C_PD_WIDTH-1:0]      out_pd_value;
  logic [C_ID_WIDTH-1:0]      out_id_value;

  logic                       in_update_valid;
  logic [C_COUNTER_WIDTH-1:0] in_counter_data_new;
  logic [C_ID_WIDTH-1:0]      in_id_data_next;

  logic                       out_init_done;
  logic                       out_wb_mismatch;

  modport master (
    output in_pkt_valid, in_pkt_id, in_pkt_len,
    output in_update_valid, in_counter_data_new, in_id_data_next,
    input  in_ready,
    input  out_gen_counter_valid, out_gen_counter_value,
    input  out_pd_valid, out_pd_value, out_id_value,
    input  out_init_done, out_wb_mismatch
  );

  modport slave (
    input  in_pkt_valid, in_pkt_id, in_pkt_len,
    input  in_update_valid, in_counter_data_new, in_id_data_next,
    output in_ready,
    output out_gen_counter_valid, out_gen_counter_value,
    output out_pd_valid, out_pd_value, out_id_value,
    output out_init_done, out_wb_mismatch
  );

endinterface

// File: rtl/flow_counter_ram.sv
// ---------------------------------------------------------------------------
// flow_counter_ram
// Simple dual-port table: one write port, one read port, one-cycle read
// latency. A read and a write to the same address in the same cycle return
// the old contents (read-first). Contents are not reset; owners clear them.
// Ports:
//   clk        clock
//   i_wr_en    write enable
//   i_wr_addr  write address
//   i_wr_data  write data
//   i_rd_en    read enable; o_rd_data updates on the following cycle
//   i_rd_addr  read address
//   o_rd_data  registered read data (holds when i_rd_en is 0)
// ---------------------------------------------------------------------------
module flow_counter_ram #(
  parameter int C_ADDR_WIDTH = 12,
  parameter int C_DATA_WIDTH = 20
) (
  input  logic                    clk,
  input  logic                    i_wr_en,
  input  logic [C_ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [C_DATA_WIDTH-1:0] i_wr_data,
  input  logic                    i_rd_en,
  input  logic [C_ADDR_WIDTH-1:0] i_rd_addr,
  output logic [C_DATA_WIDTH-1:0] o_rd_data
);

  localparam int LP_DEPTH = 1 << C_ADDR_WIDTH;

  logic [C_DATA_WIDTH-1:0] r_mem [LP_DEPTH];
  logic [C_DATA_WIDTH-1:0] r_rd_data;

  // Both accesses are non-blocking in one process, so a same-address read
  // samples the array before this edge's write lands.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/flow_counter_lookup.sv
// ---------------------------------------------------------------------------
// flow_counter_lookup
// Front stage of the probabilistic flow-counter update pipeline. Holds the
// per-flow counter table, looks up the counter of every accepted packet and
// presents either an exact new value (small counters) or a probability
// threshold pd (large counters) to the update stage, which writes the final
// counter back three cycles after acceptance.
//
// Timing for a packet accepted at cycle t:
//   t    read issued
//   t+1  S1: table data returns, results computed
//   t+2  S2: registered results valid for one cycle
//   t+3  S3: write-back expected from the update stage
// in_ready drops while S1/S2/S3 hold the arriving ID, so a repeat of the same
// flow is accepted at t+4 at the earliest and reads the committed write-back.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset; flushes and re-clears table
//   bus          flow_counter_lookup_if.slave (descriptor in, results out,
//                write-back in, init_done / wb_mismatch status)
//   o_dbg_state  current controller state (INIT / RUN)
// ---------------------------------------------------------------------------
module flow_counter_lookup
  import flow_counter_lookup_pkg::*;
#(
  parameter int C_LENGTH_WIDTH  = LP_LENGTH_WIDTH,
  parameter int C_ID_WIDTH      = LP_ID_WIDTH,
  parameter int C_COUNTER_WIDTH = LP_COUNTER_WIDTH,
  parameter int C_PD_WIDTH      = LP_PD_WIDTH,
  parameter int C_SMALL_THRESH  = LP_SMALL_THRESH
) (
  input  logic                  clk,
  input  logic                  rst,
  flow_counter_lookup_if.slave  bus,
  output state_e                o_dbg_state
);

  localparam logic [C_ID_WIDTH-1:0] LP_LAST_ADDR = '1;
  localparam logic [C_ID_WIDTH-1:0] LP_ADDR_ONE  = C_ID_WIDTH'(1);
  localparam logic [63:0]           LP_THRESH64  = 64'(C_SMALL_THRESH);

  // Controller
  state_e                     r_state;
  logic [C_ID_WIDTH-1:0]      r_init_addr;
  logic                       r_init_done;

  // S1: lookup in flight
  logic                       r_s1_valid;
  logic [C_ID_WIDTH-1:0]      r_s1_id;
  logic [C_LENGTH_WIDTH-1:0]  r_s1_len;

  // S2: registered results
  logic                       r_s2_valid;
  logic [C_ID_WIDTH-1:0]      r_s2_id;
  logic                       r_gen_valid;
  logic [C_COUNTER_WIDTH-1:0] r_gen_value;
  logic                       r_pd_valid;
  logic [C_PD_WIDTH-1:0]      r_pd_value;

  // S3: awaiting write-back
  logic                       r_s3_valid;
  logic [C_ID_WIDTH-1:0]      r_s3_id;

  logic                       r_wb_mismatch;

  // Table ports
  logic                       w_ram_we;
  logic [C_ID_WIDTH-1:0]      w_ram_waddr;
  logic [C_COUNTER_WIDTH-1:0] w_ram_wdata;
  logic                       w_ram_re;
  logic [C_COUNTER_WIDTH-1:0] w_ram_rdata;

  // Handshake / hazard
  logic                       w_hazard;
  logic                       w_ready;
  logic                       w_accept;

  // S1 datapath
  logic                       w_small;
  logic [C_COUNTER_WIDTH-1:0] w_sum;
  logic [C_PD_WIDTH-1:0]      w_pd;
  logic [C_COUNTER_WIDTH-1:0] w_gen_next;
  logic [C_PD_WIDTH-1:0]      w_pd_next;

  logic                       w_wb_err;

  // ---------------------------------------------------------------------------
  // Hazard scoreboard: any live stage carrying the same flow ID blocks entry.
  // ---------------------------------------------------------------------------
  assign w_hazard = (r_s1_valid && (r_s1_id == bus.in_pkt_id)) ||
                    (r_s2_valid && (r_s2_id == bus.in_pkt_id)) ||
                    (r_s3_valid && (r_s3_id == bus.in_pkt_id));

  assign w_ready  = (r_state == ST_RUN) && !w_hazard;
  assign w_accept = bus.in_pkt_valid && w_ready;

  // ---------------------------------------------------------------------------
  // Table write port: the clear sweep owns it during INIT, the update stage
  // owns it during RUN. Nothing is written in a reset cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_ram_we    = 1'b0;
    w_ram_waddr = '0;
    w_ram_wdata = '0;
    if (!rst) begin
      if (r_state == ST_INIT) begin
        w_ram_we    = 1'b1;
        w_ram_waddr = r_init_addr;
        w_ram_wdata = '0;
      end else begin
        w_ram_we    = bus.in_update_valid;
        w_ram_waddr = bus.in_id_data_next;
        w_ram_wdata = bus.in_counter_data_new;
      end
    end
  end

  assign w_ram_re = w_accept;

  flow_counter_ram #(
    .C_ADDR_WIDTH (C_ID_WIDTH),
    .C_DATA_WIDTH (C_COUNTER_WIDTH)
  ) u_table (
    .clk       (clk),
    .i_wr_en   (w_ram_we),
    .i_wr_addr (w_ram_waddr),
    .i_wr_data (w_ram_wdata),
    .i_rd_en   (w_ram_re),
    .i_rd_addr (bus.in_pkt_id),
    .o_rd_data (w_ram_rdata)
  );

  // ---------------------------------------------------------------------------
  // S1 result computation from the returned counter.
  // ---------------------------------------------------------------------------
  assign w_small = 64'(w_ram_rdata) < LP_THRESH64;
  assign w_sum   = C_COUNTER_WIDTH'(sat_add(64'(w_ram_rdata), 64'(r_s1_len),
                                            C_COUNTER_WIDTH));
  assign w_pd    = C_PD_WIDTH'(pd_calc(64'(w_ram_rdata), LP_THRESH64,
                                       C_COUNTER_WIDTH, C_PD_WIDTH));

  // Large counters pass the current value through unchanged; the update
  // stage decides whether to increment it using pd.
  assign w_gen_next = w_small ? w_sum : w_ram_rdata;
  assign w_pd_next  = w_small ? '0    : w_pd;

  // Write-back must line up exactly with S3: a write without S3, S3 without
  // a write, or a write to a different flow all indicate a broken partner.
  assign w_wb_err = (bus.in_update_valid != r_s3_valid) ||
                    (bus.in_update_valid && r_s3_valid &&
                     (bus.in_id_data_next != r_s3_id));

  // ---------------------------------------------------------------------------
  // Controller, pipeline and status registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_INIT;
      r_init_addr   <= '0;
      r_init_done   <= 1'b0;
      r_s1_valid    <= 1'b0;
      r_s1_id       <= '0;
      r_s1_len      <= '0;
      r_s2_valid    <= 1'b0;
      r_s2_id       <= '0;
      r_gen_valid   <= 1'b0;
      r_gen_value   <= '0;
      r_pd_valid    <= 1'b0;
      r_pd_value    <= '0;
      r_s3_valid    <= 1'b0;
      r_s3_id       <= '0;
      r_wb_mismatch <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_init_addr <= r_init_addr + LP_ADDR_ONE;
          if (r_init_addr == LP_LAST_ADDR) begin
            r_state     <= ST_RUN;
            r_init_done <= 1'b1;
          end
        end
        ST_RUN: begin
          r_init_done <= 1'b1;
        end
        default: begin
          r_state <= ST_INIT;
        end
      endcase

      // S1
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_id  <= bus.in_pkt_id;
        r_s1_len <= bus.in_pkt_len;
      end

      // S2: valids pulse, data holds between packets
      r_s2_valid  <= r_s1_valid;
      r_gen_valid <= r_s1_valid && w_small;
      r_pd_valid  <= r_s1_valid && !w_small;
      if (r_s1_valid) begin
        r_s2_id     <= r_s1_id;
        r_gen_value <= w_gen_next;
        r_pd_value  <= w_pd_next;
      end

      // S3
      r_s3_valid <= r_s2_valid;
      r_s3_id    <= r_s2_id;

      if ((r_state == ST_RUN) && w_wb_err) begin
        r_wb_mismatch <= 1'b1;
      end
    end
  end

  assign bus.in_ready              = w_ready;
  assign bus.out_gen_counter_valid = r_gen_valid;
  assign bus.out_gen_counter_value = r_gen_value;
  assign bus.out_pd_valid          = r_pd_valid;
  assign bus.out_pd_value          = r_pd_value;
  assign bus.out_id_value          = r_s2_id;
  assign bus.out_init_done         = r_init_done;
  assign bus.out_wb_mismatch       = r_wb_mismatch;
  assign o_dbg_state               = r_state;

endmodule

// File: tb/tb_flow_counter_lookup.sv
// ---------------------------------------------------------------------------
// tb_flow_counter_lookup
// Two instances share one stimulus stream: dut_a uses a small-counter
// threshold of 16 (exact and probabilistic paths), dut_b uses 2^20 so every
// counter takes the exact path and saturation is visible. The bench plays
// the update stage, answering each result with a write-back one cycle later,
// and predicts outputs from a plain counter array.
// ---------------------------------------------------------------------------
module tb_flow_counter_lookup;
  import flow_counter_lookup_pkg::*;

  localparam int     ID_W     = 4;
  localparam int     N_ID     = 1 << ID_W;
  localparam longint CMAX     = (64'd1 << 20) - 1;
  localparam longint THRESH_A = 16;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  flow_counter_lookup_if #(.C_ID_WIDTH(ID_W)) bus_a ();
  flow_counter_lookup_if #(.C_ID_WIDTH(ID_W)) bus_b ();
  state_e dbg_a;
  state_e dbg_b;

  assign bus_b.in_pkt_valid        = bus_a.in_pkt_valid;
  assign bus_b.in_pkt_id           = bus_a.in_pkt_id;
  assign bus_b.in_pkt_len          = bus_a.in_pkt_len;
  assign bus_b.in_update_valid     = bus_a.in_update_valid;
  assign bus_b.in_counter_data_new = bus_a.in_counter_data_new;
  assign bus_b.in_id_data_next     = bus_a.in_id_data_next;

  flow_counter_lookup #(.C_ID_WIDTH(ID_W), .C_SMALL_THRESH(16)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .o_dbg_state(dbg_a));

  flow_counter_lookup #(.C_ID_WIDTH(ID_W), .C_SMALL_THRESH(1 << 20)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .o_dbg_state(dbg_b));

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    int          cyc;
    logic [3:0]  id;
    logic        a_gen;
    logic [19:0] a_val;
    logic        a_pd;
    logic [31:0] a_pdv;
    logic [19:0] b_val;
  } exp_t;

  exp_t        exp_q[$];
  longint      model_tab[N_ID];
  int          last_acc[N_ID];
  int          cyc;
  int          n_vec;
  int          n_err;
  bit          run_exp;
  bit          exp_mm;
  logic        wb_v;
  logic [3:0]  wb_id;
  logic [19:0] wb_data;
  longint      wb_override;
  logic [31:0] cap_a_pdv;
  logic [19:0] cap_a_val;
  logic [19:0] cap_b_val;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Counter rules applied to the table value of a flow.
  function automatic exp_t predict(input int id, input int len);
    exp_t   e;
    longint c;
    longint sum;
    longint sh;
    c   = model_tab[id];
    sum = c + len;
    if (sum > CMAX) sum = CMAX;
    e     = '0;
    e.id  = 4'(id);
    e.b_val = sum[19:0];
    if (c < THRESH_A) begin
      e.a_gen = 1'b1;
      e.a_val = sum[19:0];
    end else begin
      e.a_pd  = 1'b1;
      e.a_val = c[19:0];
      sh      = c - THRESH_A + 1;
      if (c == CMAX || sh >= 32) e.a_pdv = 32'd0;
      else                       e.a_pdv = 32'hFFFF_FFFF >> sh;
    end
    return e;
  endfunction

  // ---------------- driver: one clock cycle ----------------
  task automatic step(input bit v, input int id, input int len,
                      input bit force_wb, output bit acc);
    exp_t   e;
    bit     exp_rdy;
    longint nv;
    @(negedge clk);
    bus_a.in_pkt_valid = v;
    bus_a.in_pkt_id    = 4'(id);
    bus_a.in_pkt_len   = 16'(len);
    if (force_wb) begin
      bus_a.in_update_valid     = 1'b1;
      bus_a.in_id_data_next     = 4'(id);
      bus_a.in_counter_data_new = 20'(len);
      model_tab[id] = len;
    end else begin
      bus_a.in_update_valid     = wb_v;
      bus_a.in_id_data_next     = wb_id;
      bus_a.in_counter_data_new = wb_data;
    end
    #1;
    wb_v = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      chk("a_gen_valid", bus_a.out_gen_counter_valid, e.a_gen);
      chk("a_pd_valid",  bus_a.out_pd_valid, e.a_pd);
      chk("a_id",        bus_a.out_id_value, e.id);
      chk("a_gen_value", bus_a.out_gen_counter_value, e.a_val);
      if (e.a_pd) chk("a_pd_value", bus_a.out_pd_value, e.a_pdv);
      chk("b_gen_valid", bus_b.out_gen_counter_valid, 1);
      chk("b_pd_valid",  bus_b.out_pd_valid, 0);
      chk("b_id",        bus_b.out_id_value, e.id);
      chk("b_gen_value", bus_b.out_gen_counter_value, e.b_val);
      cap_a_pdv = bus_a.out_pd_value;
      cap_a_val = bus_a.out_gen_counter_value;
      cap_b_val = bus_b.out_gen_counter_value;
      // Act as the update stage: exact path keeps the new value, the
      // probabilistic path increments by 0 or 1 without passing the maximum.
      if (wb_override >= 0) begin
        nv = wb_override;
        wb_override = -1;
      end else if (e.a_gen) begin
        nv = e.a_val;
      end else begin
        nv = longint'(e.a_val) + $urandom_range(0, 1);
        if (nv > CMAX) nv = CMAX;
      end
      wb_v    = 1'b1;
      wb_id   = e.id;
      wb_data = nv[19:0];
      model_tab[e.id] = nv;
    end else begin
      chk("a_idle_valids", {bus_a.out_gen_counter_valid, bus_a.out_pd_valid}, 0);
      chk("b_idle_valids", {bus_b.out_gen_counter_valid, bus_b.out_pd_valid}, 0);
    end
    exp_rdy = run_exp && (cyc - last_acc[id] >= 4);
    chk("a_in_ready", bus_a.in_ready, exp_rdy);
    chk("b_in_ready", bus_b.in_ready, exp_rdy);
    acc = v && bus_a.in_ready;
    if (acc) begin
      e = predict(id, len);
      e.cyc = cyc + 2;
      exp_q.push_back(e);
      last_acc[id] = cyc;
    end
    chk("a_wb_mismatch", bus_a.out_wb_mismatch, exp_mm);
    chk("b_wb_mismatch", bus_b.out_wb_mismatch, exp_mm);
    chk("a_init_done",   bus_a.out_init_done, run_exp);
    if (force_wb) exp_mm = 1'b1;
    cyc++;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, acc);
  endtask

  // Reset, check reset values, then time the table clear.
  task automatic do_reset();
    int cnt;
    @(negedge clk);
    rst = 1'b1;
    bus_a.in_pkt_valid    = 1'b0;
    bus_a.in_pkt_id       = '0;
    bus_a.in_pkt_len      = '0;
    bus_a.in_update_valid = 1'b0;
    bus_a.in_id_data_next = '0;
    bus_a.in_counter_data_new = '0;
    @(negedge clk);
    #1;
    chk("rst_a_outs", {bus_a.out_gen_counter_valid, bus_a.out_pd_valid,
                       bus_a.out_init_done, bus_a.out_wb_mismatch, bus_a.in_ready}, 0);
    chk("rst_a_gen_value", bus_a.out_gen_counter_value, 0);
    chk("rst_a_pd_value",  bus_a.out_pd_value, 0);
    chk("rst_a_id",        bus_a.out_id_value, 0);
    chk("rst_b_outs", {bus_b.out_gen_counter_valid, bus_b.out_pd_valid,
                       bus_b.out_init_done, bus_b.out_wb_mismatch, bus_b.in_ready}, 0);
    chk("rst_a_state", dbg_a, ST_INIT);
    rst = 1'b0;
    for (int i = 0; i < N_ID; i++) begin
      model_tab[i] = 0;
      last_acc[i]  = -100;
    end
    exp_q.delete();
    wb_v = 1'b0; wb_id = '0; wb_data = '0;
    wb_override = -1;
    exp_mm  = 1'b0;
    run_exp = 1'b0;
    cnt = 0;
    while (!bus_a.in_ready && cnt < 100) begin
      cnt++;
      @(negedge clk);
      #1;
    end
    chk("init_cycles", cnt, N_ID);
    chk("init_done_a", bus_a.out_init_done, 1);
    chk("init_done_b", bus_b.out_init_done, 1);
    chk("run_state_a", dbg_a, ST_RUN);
    chk("run_state_b", dbg_b, ST_RUN);
    run_exp = 1'b1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    bit acc;
    int stalls;
    bit pv;
    int pid;
    int plen;
    n_vec = 0; n_err = 0; cyc = 0;
    rst = 1'b1;
    do_reset();

    // fresh table reads 0 for every flow
    for (int i = 0; i < N_ID; i++) begin
      step(1, i, 0, 0, acc);
      chk("fresh_acc", acc, 1);
    end
    idle(5);

    // exact path: id 3, len 100
    step(1, 3, 100, 0, acc);
    idle(4);
    chk("id3_value", cap_a_val, 20'd200 - 20'd100);

    // preload id 5 with 20, then probabilistic path
    step(1, 5, 20, 0, acc);
    idle(4);
    step(1, 5, 0, 0, acc);
    idle(4);
    chk("id5_pd", cap_a_pdv, 32'h07FF_FFFF);
    chk("id5_val", cap_a_val, 20);

    // same flow back to back: second waits three cycles
    step(1, 7, 10, 0, acc);
    stalls = 0;
    acc = 1'b0;
    while (!acc && stalls < 10) begin
      step(1, 7, 5, 0, acc);
      if (!acc) stalls++;
    end
    chk("same_id_stalls", stalls, 3);
    idle(4);
    chk("id7_second_value", cap_a_val, 15);

    // distinct flows stream at full rate
    for (int i = 1; i <= 4; i++) begin
      step(1, i, i * 3, 0, acc);
      chk("stream_acc", acc, 1);
    end
    idle(5);

    // saturation on dut_b: preload id 2 with 2^20-10, then add 100
    wb_override = CMAX - 9;
    step(1, 2, 0, 0, acc);
    idle(4);
    step(1, 2, 100, 0, acc);
    idle(4);
    chk("sat_b_value", cap_b_val, 20'hF_FFFF);

    // frozen counter: id 9 at maximum yields pd 0
    wb_override = CMAX;
    step(1, 9, 0, 0, acc);
    idle(4);
    step(1, 9, 50, 0, acc);
    idle(4);
    chk("frozen_pd", cap_a_pdv, 0);

    // randomized traffic with the source holding each descriptor
    pv = 1'b0; pid = 0; plen = 0;
    for (int i = 0; i < 400; i++) begin
      if (!pv && $urandom_range(0, 3) != 0) begin
        pv   = 1'b1;
        pid  = $urandom_range(0, N_ID - 1);
        plen = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 65535)
                                           : $urandom_range(0, 40);
      end
      step(pv, pid, plen, 0, acc);
      if (acc) pv = 1'b0;
    end
    idle(6);

    // stray write-back with S3 empty: sticky flag, write still lands
    step(0, 4, 77, 1, acc);
    idle(3);
    step(1, 4, 0, 0, acc);
    idle(5);
    chk("stray_wb_written", cap_a_val, 77);

    // reset clears the flag and the table
    do_reset();
    step(1, 4, 1, 0, acc);
    idle(4);
    chk("post_reset_value", cap_a_val, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
